// File: rtl/scan2000_pkg.sv
// -----------------------------------------------------------------------------
// scan2000_pkg
//   Shared types and defaults for the scanner relay bank.
//   - seq_state_t : break-before-make sequencer states
//   - *_DEF       : default relay word geometry and phase timing
//   - max_int     : elaboration-time helper used to size the shared timer
// -----------------------------------------------------------------------------
package scan2000_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    SETTLE = 2'd2
  } seq_state_t;

  localparam int NBITS_DEF         = 24;
  localparam int NCH_DEF           = 20;
  localparam int BREAK_CYCLES_DEF  = 24000;
  localparam int SETTLE_CYCLES_DEF = 36000;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/relay_sequencer_cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
//   Loadable down-counter shared by the BREAK and SETTLE phases.
//   The count parks at zero rather than wrapping.
// Ports:
//   CLK_SYS  in   1  system clock
//   RESET    in   1  asynchronous, active-low reset
//   load     in   1  load 'value' into the counter on the next edge
//   value    in   W  value to load
//   zero     out  1  counter currently equals zero
// -----------------------------------------------------------------------------
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         CLK_SYS,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Counter register: load has priority, otherwise count down and hold at zero.
  always_ff @(posedge CLK_SYS or negedge RESET) begin
    if (!RESET) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= value;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/relay_sequencer.sv
// -----------------------------------------------------------------------------
// relay_sequencer
//   Break-before-make scheduler for the scanner relay bank. A new relay word
//   first opens every relay that must open (RELAY_OUT = cur & new), waits
//   BREAK_CYCLES, closes the new relays (RELAY_OUT = new), then waits
//   SETTLE_CYCLES before pulsing DONE. One word is buffered while busy; the
//   latest strobe wins, and a fresh strobe in IDLE beats the buffered word.
// Ports:
//   CLK_SYS     in   1      system clock
//   RESET       in   1      asynchronous, active-low reset
//   WORD_IN     in   NBITS  relay word, valid with DATA_READY
//   DATA_READY  in   1      one-cycle strobe from the input shift register
//   RELAY_OUT   out  NBITS  relay drive, 1 = closed
//   BUSY        out  1      sequence in progress (BREAK or SETTLE)
//   DONE        out  1      one-cycle pulse: word applied and settled, or no-op
//   PENDING     out  1      a buffered word is waiting
//   ERROR       out  1      one-cycle pulse: word rejected
// Build option:
//   CONFLICT_CHECK_EN - when defined, a starting word with more than one
//   channel relay (bits [NCH-1:0]) closed is rejected with an ERROR pulse.
//   When undefined every word is applied and ERROR stays 0.
// -----------------------------------------------------------------------------
module relay_sequencer
  import scan2000_pkg::*;
#(
  parameter int NBITS         = NBITS_DEF,
  parameter int NCH           = NCH_DEF,
  parameter int BREAK_CYCLES  = BREAK_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             CLK_SYS,
  input  logic             RESET,
  input  logic [NBITS-1:0] WORD_IN,
  input  logic             DATA_READY,
  output logic [NBITS-1:0] RELAY_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PENDING,
  output logic             ERROR
);

  localparam int CW = $clog2(max_int(BREAK_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CW-1:0] BREAK_LOAD_C  = CW'(BREAK_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD_C = CW'(SETTLE_CYCLES - 1);

  // True when more than one channel relay would be closed at once.
  function automatic logic multi_hot(input logic [NCH-1:0] ch);
    return (ch & (ch - {{(NCH-1){1'b0}}, 1'b1})) != {NCH{1'b0}};
  endfunction

  seq_state_t       state_r;
  seq_state_t       state_nxt_s;

  logic [NBITS-1:0] relay_r;
  logic [NBITS-1:0] relay_nxt_s;
  logic [NBITS-1:0] apply_word_r;
  logic [NBITS-1:0] apply_word_nxt_s;
  logic [NBITS-1:0] pend_word_r;
  logic [NBITS-1:0] pend_word_nxt_s;
  logic             pending_r;
  logic             pending_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic             error_r;
  logic             error_nxt_s;

  logic             timer_load_s;
  logic [CW-1:0]    timer_value_s;
  logic             timer_zero_s;

  logic             start_s;
  logic [NBITS-1:0] start_word_s;
  logic             same_s;
  logic             reject_en_s;
  logic             reject_s;

`ifdef CONFLICT_CHECK_EN
  assign reject_en_s = 1'b1;
`else
  assign reject_en_s = 1'b0;
`endif

  // A fresh strobe outranks the buffered word; the check runs at start time.
  assign start_s      = DATA_READY | pending_r;
  assign start_word_s = DATA_READY ? WORD_IN : pend_word_r;
  assign same_s       = (start_word_s == relay_r);
  assign reject_s     = reject_en_s & multi_hot(start_word_s[NCH-1:0]);

  cycle_timer #(
    .W (CW)
  ) u_timer (
    .CLK_SYS (CLK_SYS),
    .RESET   (RESET),
    .load    (timer_load_s),
    .value   (timer_value_s),
    .zero    (timer_zero_s)
  );

  // State register.
  always_ff @(posedge CLK_SYS or negedge RESET) begin
    if (!RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s && !reject_s && !same_s) begin
          state_nxt_s = BREAK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BREAK: begin
        if (timer_zero_s) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = BREAK;
        end
      end
      SETTLE: begin
        if (timer_zero_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output and datapath next values; all of these are registered below.
  always_comb begin
    relay_nxt_s      = relay_r;
    apply_word_nxt_s = apply_word_r;
    pend_word_nxt_s  = pend_word_r;
    pending_nxt_s    = pending_r;
    done_nxt_s       = 1'b0;
    error_nxt_s      = 1'b0;
    timer_load_s     = 1'b0;
    timer_value_s    = {CW{1'b0}};
    case (state_r)
      IDLE: begin
        if (start_s) begin
          // Either source consumes (or discards) the buffered word.
          pending_nxt_s = 1'b0;
          if (reject_s) begin
            error_nxt_s = 1'b1;
          end else if (same_s) begin
            done_nxt_s = 1'b1;
          end else begin
            relay_nxt_s      = relay_r & start_word_s;
            apply_word_nxt_s = start_word_s;
            timer_load_s     = 1'b1;
            timer_value_s    = BREAK_LOAD_C;
          end
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      BREAK: begin
        if (DATA_READY) begin
          pend_word_nxt_s = WORD_IN;
          pending_nxt_s   = 1'b1;
        end else begin
          pending_nxt_s   = pending_r;
        end
        if (timer_zero_s) begin
          relay_nxt_s   = apply_word_r;
          timer_load_s  = 1'b1;
          timer_value_s = SETTLE_LOAD_C;
        end else begin
          relay_nxt_s   = relay_r;
        end
      end
      SETTLE: begin
        if (DATA_READY) begin
          pend_word_nxt_s = WORD_IN;
          pending_nxt_s   = 1'b1;
        end else begin
          pending_nxt_s   = pending_r;
        end
        if (timer_zero_s) begin
          done_nxt_s = 1'b1;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      default: begin
        relay_nxt_s = relay_r;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge CLK_SYS or negedge RESET) begin
    if (!RESET) begin
      relay_r      <= {NBITS{1'b0}};
      apply_word_r <= {NBITS{1'b0}};
      pend_word_r  <= {NBITS{1'b0}};
      pending_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      relay_r      <= relay_nxt_s;
      apply_word_r <= apply_word_nxt_s;
      pend_word_r  <= pend_word_nxt_s;
      pending_r    <= pending_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      error_r      <= error_nxt_s;
    end
  end

  assign RELAY_OUT = relay_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign PENDING   = pending_r;
  assign ERROR     = error_r;

endmodule

// File: tb/tb_relay_sequencer.sv
// -----------------------------------------------------------------------------
// tb_relay_sequencer
//   Directed bench for relay_sequencer with BREAK_CYCLES=4, SETTLE_CYCLES=6.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_relay_sequencer;

  logic        CLK_SYS;
  logic        RESET;
  logic [23:0] WORD_IN;
  logic        DATA_READY;
  logic [23:0] RELAY_OUT;
  logic        BUSY;
  logic        DONE;
  logic        PENDING;
  logic        ERROR;

  int checks_r;
  int errors_r;

  relay_sequencer #(
    .NBITS         (24),
    .NCH           (20),
    .BREAK_CYCLES  (4),
    .SETTLE_CYCLES (6)
  ) dut (
    .CLK_SYS    (CLK_SYS),
    .RESET      (RESET),
    .WORD_IN    (WORD_IN),
    .DATA_READY (DATA_READY),
    .RELAY_OUT  (RELAY_OUT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .PENDING    (PENDING),
    .ERROR      (ERROR)
  );

  initial CLK_SYS = 1'b0;
  always #5 CLK_SYS = ~CLK_SYS;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_SYS);
    #1;
  endtask

  // Present one strobe; on return the strobe edge (k) has just passed.
  task automatic send(input logic [23:0] w);
    WORD_IN    = w;
    DATA_READY = 1'b1;
    tick();
    DATA_READY = 1'b0;
  endtask

  // Time bound for the whole run.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen10;
    checks_r   = 0;
    errors_r   = 0;
    RESET      = 1'b0;
    WORD_IN    = 24'h000000;
    DATA_READY = 1'b0;
    tick();
    tick();
    chk("rst_relay",   RELAY_OUT, 32'h0);
    chk("rst_busy",    BUSY,      32'h0);
    chk("rst_done",    DONE,      32'h0);
    chk("rst_pending", PENDING,   32'h0);
    chk("rst_error",   ERROR,     32'h0);
    RESET = 1'b1;

    // 1: first word from reset, exact phase timing.
    send(24'h000001);
    chk("t1_k_relay", RELAY_OUT, 32'h0);
    chk("t1_k_busy",  BUSY,      32'h1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) chk("t1_k3_relay", RELAY_OUT, 32'h0);
      if (i == 4) chk("t1_k4_relay", RELAY_OUT, 32'h1);
      if (i == 9) begin
        chk("t1_k9_busy", BUSY, 32'h1);
        chk("t1_k9_done", DONE, 32'h0);
      end
      if (i == 10) begin
        chk("t1_k10_done", DONE, 32'h1);
        chk("t1_k10_busy", BUSY, 32'h0);
      end
    end
    tick();
    chk("t1_done_pulse", DONE, 32'h0);

    // 2: cur=3, then 6 -> break shows 2, close shows 6.
    send(24'h000003);
    chk("t2a_break", RELAY_OUT, 32'h1);
    for (int i = 1; i <= 10; i++) tick();
    chk("t2a_done", DONE, 32'h1);
    chk("t2a_relay", RELAY_OUT, 32'h3);
    send(24'h000006);
    chk("t2_break_k", RELAY_OUT, 32'h2);
    tick(); tick(); tick();
    chk("t2_break_k3", RELAY_OUT, 32'h2);
    tick();
    chk("t2_close", RELAY_OUT, 32'h6);
    for (int i = 5; i <= 10; i++) tick();
    chk("t2_done", DONE, 32'h1);

    // 3: same word -> no-op, DONE next cycle, no BUSY.
    send(24'h000006);
    chk("t3_done",  DONE,      32'h1);
    chk("t3_busy",  BUSY,      32'h0);
    chk("t3_relay", RELAY_OUT, 32'h6);
    tick();
    chk("t3_done_pulse", DONE, 32'h0);
    chk("t3_busy2",      BUSY, 32'h0);

    // 4: two strobes while busy; the latest wins.
    send(24'h000008);
    send(24'h000010);
    send(24'h000020);
    chk("t4_pending", PENDING, 32'h1);
    seen10 = 1'b0;
    for (int i = 3; i <= 21; i++) begin
      tick();
      if (RELAY_OUT == 24'h000010) seen10 = 1'b1;
      if (i == 4) chk("t4_relay8", RELAY_OUT, 32'h8);
      if (i == 10) begin
        chk("t4_done1",    DONE,    32'h1);
        chk("t4_pend_hold", PENDING, 32'h1);
      end
      if (i == 11) begin
        chk("t4_start_busy", BUSY,      32'h1);
        chk("t4_pend_clr",   PENDING,   32'h0);
        chk("t4_break",      RELAY_OUT, 32'h0);
      end
      if (i == 15) chk("t4_close", RELAY_OUT, 32'h20);
      if (i == 21) chk("t4_done2", DONE, 32'h1);
    end
    chk("t4_never_10", seen10, 32'h0);

    // 5: async reset mid-BREAK with a word buffered.
    send(24'h000040);
    send(24'h000080);
    chk("t5_pre_pending", PENDING, 32'h1);
    #2 RESET = 1'b0;
    #1;
    chk("t5_relay",   RELAY_OUT, 32'h0);
    chk("t5_busy",    BUSY,      32'h0);
    chk("t5_pending", PENDING,   32'h0);
    #2 RESET = 1'b1;
    tick();
    chk("t5_idle_after", BUSY, 32'h0);
    send(24'h000001);
    chk("t5_k_busy", BUSY, 32'h1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) chk("t5_close", RELAY_OUT, 32'h1);
      if (i == 10) chk("t5_done", DONE, 32'h1);
    end

    // 6: two channel relays at once.
    send(24'h000003);
`ifdef CONFLICT_CHECK_EN
    chk("t6_error", ERROR,     32'h1);
    chk("t6_done",  DONE,      32'h0);
    chk("t6_relay", RELAY_OUT, 32'h1);
    chk("t6_busy",  BUSY,      32'h0);
    tick();
    chk("t6_error_pulse", ERROR, 32'h0);
    chk("t6_done2",       DONE,  32'h0);
`else
    chk("t6_error", ERROR,     32'h0);
    chk("t6_break", RELAY_OUT, 32'h1);
    chk("t6_busy",  BUSY,      32'h1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) chk("t6_close", RELAY_OUT, 32'h3);
      if (i == 10) chk("t6_done", DONE, 32'h1);
    end
    chk("t6_error_end", ERROR, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
